// File: rtl/rcpu_mem_arbiter_pkg.sv
// Shared definitions for the rcpu memory arbiter.
// - WORD_W            : RAM / CPU data and address width
// - MEM_WORDS_DEFAULT : default RAM depth, used for the debug range check
// - arb_state_e       : CPU sequencing states (halted, starting, running)
// - addr_in_range()   : debug address range check against the RAM depth
package rcpu_mem_arbiter_pkg;

    localparam int unsigned WORD_W            = 16;
    localparam int unsigned MEM_WORDS_DEFAULT = 4096;

    typedef logic [0:WORD_W-1] word_t;

    typedef enum logic [1:0] {
        StHalt  = 2'd0,
        StStart = 2'd1,
        StRun   = 2'd2
    } arb_state_e;

    function automatic logic addr_in_range(word_t addr, int unsigned words);
        return 32'(addr) < words;
    endfunction

endpackage

// File: rtl/rcpu_mem_arbiter_if.sv
// Bus bundle around the arbiter: CPU run control, CPU memory port, debug/loader
// port and the RAM-side read/write ports.
// - slave  : arbiter view (takes requests, drives grants and RAM ports)
// - master : environment view (CPU, debug host and RAM model)
interface rcpu_mem_arbiter_if;
    import rcpu_mem_arbiter_pkg::*;

    // Run control
    logic  run_req;
    logic  halt_req;
    logic  cpu_resetq;
    logic  running;
    // CPU memory port
    logic  cpu_read_enable;
    logic  cpu_write_enable;
    word_t cpu_read_addr;
    word_t cpu_write_addr;
    word_t cpu_write_data;
    word_t cpu_read_data;
    // Debug / loader port
    logic  dbg_req;
    logic  dbg_we;
    word_t dbg_addr;
    word_t dbg_wdata;
    logic  dbg_gnt;
    logic  dbg_err;
    logic  dbg_rvalid;
    word_t dbg_rdata;
    logic  dbg_starved;
    // RAM ports
    logic  mem_read_enable;
    logic  mem_write_enable;
    word_t mem_read_addr;
    word_t mem_write_addr;
    word_t mem_write_data;
    word_t mem_read_data;

    modport slave (
        input  run_req, halt_req,
        output cpu_resetq, running,
        input  cpu_read_enable, cpu_write_enable, cpu_read_addr, cpu_write_addr, cpu_write_data,
        output cpu_read_data,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_gnt, dbg_err, dbg_rvalid, dbg_rdata, dbg_starved,
        output mem_read_enable, mem_write_enable, mem_read_addr, mem_write_addr, mem_write_data,
        input  mem_read_data
    );

    modport master (
        output run_req, halt_req,
        input  cpu_resetq, running,
        output cpu_read_enable, cpu_write_enable, cpu_read_addr, cpu_write_addr, cpu_write_data,
        input  cpu_read_data,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_gnt, dbg_err, dbg_rvalid, dbg_rdata, dbg_starved,
        input  mem_read_enable, mem_write_enable, mem_read_addr, mem_write_addr, mem_write_data,
        output mem_read_data
    );

endinterface

// File: rtl/rcpu_mem_arbiter_port.sv
// One RAM port's fixed-priority arbiter and mux (used for the read and the write port).
// - cpu_allowed : CPU may own the port (only while running)
// - cpu_en      : CPU access request, cpu_payload its address (and data)
// - dbg_en      : valid in-range debug request for this port, dbg_payload its address (and data)
// - mem_en      : RAM port enable, mem_payload the selected address (and data)
// - dbg_gnt     : debug request owns the port this cycle
module rcpu_mem_arbiter_port #(
    parameter int unsigned PayloadW = 16
) (
    input  logic                cpu_allowed,
    input  logic                cpu_en,
    input  logic [PayloadW-1:0] cpu_payload,
    input  logic                dbg_en,
    input  logic [PayloadW-1:0] dbg_payload,
    output logic                mem_en,
    output logic [PayloadW-1:0] mem_payload,
    output logic                dbg_gnt
);

    logic cpu_sel;

    always_comb begin
        cpu_sel     = cpu_allowed & cpu_en;
        // CPU is never stalled: debug only gets the port when the CPU leaves it idle.
        dbg_gnt     = dbg_en & ~cpu_sel;
        mem_en      = cpu_sel | dbg_gnt;
        mem_payload = dbg_gnt ? dbg_payload : cpu_payload;
    end

endmodule

// File: rtl/rcpu_mem_arbiter.sv
// RAM arbiter between rcpu and the 4096x16 ram_memory, plus CPU start/stop sequencing.
// - clk, reset : system clock, asynchronous active-high reset
// - bus        : run control, CPU memory port, debug/loader port and RAM ports
// In HALT and START the CPU is held in reset and the debug port owns the RAM. In RUN
// the CPU has fixed priority on each RAM port independently; debug fills idle slots.
// Parameters:
// - MEM_WORDS    : RAM depth for the debug range check
// - START_DELAY  : cycles spent in START before RUN (must be >= 1)
// - STARVE_LIMIT : consecutive denied debug cycles in RUN that set dbg_starved (<= 255)
module rcpu_mem_arbiter
    import rcpu_mem_arbiter_pkg::*;
#(
    parameter int unsigned MEM_WORDS    = MEM_WORDS_DEFAULT,
    parameter int unsigned START_DELAY  = 2,
    parameter int unsigned STARVE_LIMIT = 255
) (
    input logic               clk,
    input logic               reset,
    rcpu_mem_arbiter_if.slave bus
);

    localparam int unsigned StartCntW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam logic [StartCntW-1:0] StartLast = StartCntW'(START_DELAY - 1);
    localparam logic [7:0] StarveLimit = 8'(STARVE_LIMIT);

    arb_state_e            state_q, state_d;
    logic [StartCntW-1:0]  start_cnt_q, start_cnt_d;
    logic                  in_run;

    logic                  cpu_resetq_q;
    logic                  rd_tag_q;
    logic                  rvalid_q;
    word_t                 rdata_q;
    logic [7:0]            starve_cnt_q, starve_cnt_d;
    logic                  starved_q, starved_d;

    logic                  dbg_in_range;
    logic                  dbg_err;
    logic                  dbg_rd_en;
    logic                  dbg_wr_en;
    logic                  rd_gnt;
    logic                  wr_gnt;
    logic                  dbg_gnt;
    logic [2*WORD_W-1:0]   wr_mem_payload;

    // ---------------------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StHalt;
            start_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            start_cnt_q <= start_cnt_d;
        end
    end

    // ---------------------------------------------------------------------------------
    // FSM: next state (halt_req always wins)
    // ---------------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        start_cnt_d = start_cnt_q;
        unique case (state_q)
            StHalt: begin
                if (bus.run_req && !bus.halt_req) begin
                    state_d     = StStart;
                    start_cnt_d = '0;
                end
            end
            StStart: begin
                if (bus.halt_req) begin
                    state_d = StHalt;
                end else if (start_cnt_q == StartLast) begin
                    state_d = StRun;
                end else begin
                    start_cnt_d = start_cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (bus.halt_req) begin
                    state_d = StHalt;
                end
            end
            default: state_d = StHalt;
        endcase
    end

    // ---------------------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------------------
    always_comb begin
        in_run              = (state_q == StRun);
        bus.running         = in_run;
        bus.cpu_resetq      = cpu_resetq_q;
        bus.cpu_read_data   = bus.mem_read_data;
        bus.dbg_gnt         = dbg_gnt;
        bus.dbg_err         = dbg_err;
        bus.dbg_rvalid      = rvalid_q;
        bus.dbg_rdata       = rdata_q;
        bus.dbg_starved     = starved_q;
        bus.mem_write_addr  = wr_mem_payload[2*WORD_W-1:WORD_W];
        bus.mem_write_data  = wr_mem_payload[WORD_W-1:0];
    end

    // ---------------------------------------------------------------------------------
    // Debug request decode and per-port arbitration
    // ---------------------------------------------------------------------------------
    always_comb begin
        dbg_in_range = addr_in_range(bus.dbg_addr, MEM_WORDS);
        // Out-of-range requests are answered with an error and never reach the RAM.
        dbg_err      = bus.dbg_req & ~dbg_in_range;
        dbg_rd_en    = bus.dbg_req & dbg_in_range & ~bus.dbg_we;
        dbg_wr_en    = bus.dbg_req & dbg_in_range & bus.dbg_we;
    end

    assign dbg_gnt = rd_gnt | wr_gnt;

    rcpu_mem_arbiter_port #(
        .PayloadW (WORD_W)
    ) u_rd_port (
        .cpu_allowed (in_run),
        .cpu_en      (bus.cpu_read_enable),
        .cpu_payload (bus.cpu_read_addr),
        .dbg_en      (dbg_rd_en),
        .dbg_payload (bus.dbg_addr),
        .mem_en      (bus.mem_read_enable),
        .mem_payload (bus.mem_read_addr),
        .dbg_gnt     (rd_gnt)
    );

    rcpu_mem_arbiter_port #(
        .PayloadW (2 * WORD_W)
    ) u_wr_port (
        .cpu_allowed (in_run),
        .cpu_en      (bus.cpu_write_enable),
        .cpu_payload ({bus.cpu_write_addr, bus.cpu_write_data}),
        .dbg_en      (dbg_wr_en),
        .dbg_payload ({bus.dbg_addr, bus.dbg_wdata}),
        .mem_en      (bus.mem_write_enable),
        .mem_payload (wr_mem_payload),
        .dbg_gnt     (wr_gnt)
    );

    // ---------------------------------------------------------------------------------
    // Starvation tracking
    // ---------------------------------------------------------------------------------
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        starved_d    = starved_q;
        if (state_d == StHalt) begin
            starve_cnt_d = '0;
            starved_d    = 1'b0;
        end else if (in_run) begin
            if (dbg_gnt) begin
                starve_cnt_d = '0;
            end else if (bus.dbg_req && dbg_in_range && starve_cnt_q != 8'hFF) begin
                starve_cnt_d = starve_cnt_q + 8'd1;
            end
            if (starve_cnt_d >= StarveLimit) begin
                starved_d = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------------------
    // Registered outputs: CPU reset line, debug read return, starvation state
    // ---------------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_resetq_q <= 1'b0;
            rd_tag_q     <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            starve_cnt_q <= '0;
            starved_q    <= 1'b0;
        end else begin
            // Released together with the RUN transition so the first RUN cycle sees 1.
            cpu_resetq_q <= (state_d == StRun);
            // Owner tag: RAM data for this read shows up next cycle, capture it then.
            rd_tag_q     <= rd_gnt;
            rvalid_q     <= rd_tag_q;
            if (rd_tag_q) begin
                rdata_q <= bus.mem_read_data;
            end
            starve_cnt_q <= starve_cnt_d;
            starved_q    <= starved_d;
        end
    end

endmodule
